// File: rtl/win_sprite_blitter.sv
// win_sprite_blitter
//   Walks the 36x28 "win" sprite ROM one address per cycle and turns each
//   returned pixel into a VGA adapter plot at the winner-screen anchor that
//   `start` selects. The address counter runs in raster order. Column and row
//   counters run alongside it, so no multiply is needed to recover (x,y).
//   Optional build macro: WIN_TRANSPARENT_EN. When it is defined, pixels whose
//   colour equals TRANSP_KEY are not plotted.
module win_sprite_blitter #(
  parameter int                SPR_W      = 36,
  parameter int                SPR_H      = 28,
  parameter int                ADDR_W     = 17,
  parameter int                COLOUR_W   = 9,
  parameter logic [COLOUR_W-1:0] TRANSP_KEY = '0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic [2:0]          start,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [9:0]          x,
  output logic [9:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int                COL_W     = $clog2(SPR_W);
  localparam int                ROW_W     = $clog2(SPR_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPR_W * SPR_H - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(SPR_W - 1);

`ifdef WIN_TRANSPARENT_EN
  localparam bit TRANSP_ON = 1'b1;
`else
  localparam bit TRANSP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    READ,
    FLUSH,
    DONE
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [9:0]       x0;
  logic [9:0]       y0;

  // Read-side pipeline stage, aligned with rom_data.
  logic             rd_valid_d;
  logic [COL_W-1:0] col_d;
  logic [ROW_W-1:0] row_d;

  // Winner code -> top-left anchor {x0, y0}; codes outside 2..5 are invalid.
  function automatic logic [20:0] anchor_of(input logic [2:0] code);
    logic [20:0] r;
    r = '0;
    case (code)
      3'd2:    r = {1'b1, 10'd31,  10'd103};
      3'd3:    r = {1'b1, 10'd576, 10'd240};
      3'd4:    r = {1'b1, 10'd30,  10'd240};
      3'd5:    r = {1'b1, 10'd576, 10'd103};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [20:0] anchor_sel;
  assign anchor_sel = anchor_of(start);

  // Control FSM: accepts go, walks addresses in raster order, drains, then pulses done.
  // NOTE: every register here uses <= so that all state updates from one edge see the old values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      rom_addr <= '0;
      col      <= '0;
      row      <= '0;
      x0       <= '0;
      y0       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go && anchor_sel[20]) begin
            x0       <= anchor_sel[19:10];
            y0       <= anchor_sel[9:0];
            rom_addr <= '0;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (rom_addr == LAST_ADDR) begin
            state <= FLUSH;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FLUSH: begin
          // Stay until the final pixel has left the read stage.
          if (!rd_valid_d) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  logic key_hit;
  assign key_hit = TRANSP_ON && (rom_data == TRANSP_KEY);

  // Plot stage: delays col/row by one cycle to meet rom_data, then registers x/y/colour/plot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid_d <= 1'b0;
      col_d      <= '0;
      row_d      <= '0;
      plot       <= 1'b0;
      colour     <= '0;
      x          <= '0;
      y          <= '0;
    end else begin
      rd_valid_d <= (state == READ);
      col_d      <= col;
      row_d      <= row;
      plot       <= rd_valid_d && !key_hit;
      // x/y/colour only move on a real plot, so they hold between frames.
      if (rd_valid_d && !key_hit) begin
        colour <= rom_data;
        x      <= x0 + 10'(col_d);
        y      <= y0 + 10'(row_d);
      end
    end
  end

endmodule

// File: tb/tb_win_sprite_blitter.sv
// Directed bench for win_sprite_blitter with a one-cycle-latency ROM model.
// ROM contents: mode 0 -> addr[8:0]; mode 1 -> 9'h1AB at addr 37, 0 elsewhere.
module tb_win_sprite_blitter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        go;
  logic [2:0]  start;
  logic [16:0] rom_addr;
  logic [8:0]  rom_data;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [8:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;
  int rom_mode = 0;

`ifdef WIN_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  win_sprite_blitter dut (
    .clk      (clk),
    .resetn   (resetn),
    .go       (go),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  always_ff @(posedge clk) begin
    if (rom_mode == 0) rom_data <= rom_addr[8:0];
    else               rom_data <= (rom_addr == 17'd37) ? 9'h1AB : 9'h000;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] exp_colour(input int k, input int mode);
    logic [31:0] kv;
    kv = k;
    if (mode == 0) return kv[8:0];
    return (k == 37) ? 9'h1AB : 9'h000;
  endfunction

  function automatic bit exp_plot(input int k, input int mode);
    return !(TRANSP && exp_colour(k, mode) == 9'h000);
  endfunction

  // Runs one frame from the current negedge. c counts negedges after the
  // accepting edge; pixel k is expected at c = k + 2, done at c = 1010.
  // inject_c: drive go/start=5 at that cycle; reset_c: pull resetn there.
  task automatic run_frame(input string nm, input logic [2:0] st, input int x0, input int y0,
                           input int mode, input int inject_c, input int reset_c);
    int pix_err = 0;
    int n_done = 0;
    int done_c = -1;
    int first_c = -1;
    int first_x = -1;
    int first_y = -1;
    int busy_at_done = -1;
    int last_x = 0;
    int last_y = 0;
    int first_k;
    rom_mode = mode;
    first_k  = (mode == 0) ? (TRANSP ? 1 : 0) : (TRANSP ? 37 : 0);
    go = 1'b1; start = st;
    @(negedge clk);
    go = 1'b0;
    check({nm, " busy_after_go"}, 32'(busy), 32'd1);
    check({nm, " addr_after_go"}, 32'(rom_addr), 32'd0);
    for (int c = 1; c <= 1015; c++) begin
      int  k;
      bit  ep;
      @(negedge clk);
      k  = c - 2;
      ep = (k >= 0 && k < 1008) ? exp_plot(k, mode) : 1'b0;
      if (plot !== ep) pix_err++;
      if (plot === 1'b1 && ep) begin
        if (x !== 10'(x0 + k % 36) || y !== 10'(y0 + k / 36) || colour !== exp_colour(k, mode))
          pix_err++;
        if (first_c < 0) begin first_c = c; first_x = x; first_y = y; end
      end
      if (ep) begin last_x = x0 + k % 36; last_y = y0 + k / 36; end
      if (done === 1'b1) begin n_done++; done_c = c; busy_at_done = busy; end
      if (c == reset_c) begin
        resetn = 1'b0;
        #1;
        check({nm, " outputs_in_reset"},
              32'({plot, busy, done, x}) | 32'({y, colour}) | 32'(rom_addr), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        return;
      end
      if (c == inject_c) begin go = 1'b1; start = 3'd5; end
      else if (c == inject_c + 1) begin go = 1'b0; start = 3'd0; end
    end
    check({nm, " pixel_errors"}, 32'(pix_err), 32'd0);
    check({nm, " first_plot_cycle"}, 32'(first_c), 32'(first_k + 2));
    check({nm, " first_x"}, 32'(first_x), 32'(x0 + first_k % 36));
    check({nm, " first_y"}, 32'(first_y), 32'(y0 + first_k / 36));
    check({nm, " done_cycle"}, 32'(done_c), 32'd1010);
    check({nm, " done_pulses"}, 32'(n_done), 32'd1);
    check({nm, " busy_at_done"}, 32'(busy_at_done), 32'd0);
    check({nm, " x_hold"}, 32'(x), 32'(last_x));
    check({nm, " y_hold"}, 32'(y), 32'(last_y));
  endtask

  initial begin
    int activity;
    logic [2:0] bad_codes [4];
    bad_codes = '{3'd0, 3'd1, 3'd6, 3'd7};
    resetn = 1'b0; go = 1'b0; start = 3'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("reset_idle_outputs",
          32'({plot, busy, done, x}) | 32'({y, colour}) | 32'(rom_addr), 32'd0);

    // Frames at every anchor; pixel 36 (x0, y0+1) is covered by the per-pixel sweep.
    run_frame("s2", 3'd2, 31, 103, 0, -10, -1);
    check("s2_last_x", 32'(x), 32'd66);
    check("s2_last_y", 32'(y), 32'd130);
    check("s2_last_colour", 32'(colour), 32'(TRANSP ? 9'd495 : (1007 & 9'h1FF)));
    run_frame("s3", 3'd3, 576, 240, 0, -10, -1);
    run_frame("s4", 3'd4, 30, 240, 0, -10, -1);
    run_frame("s5", 3'd5, 576, 103, 0, -10, -1);

    // Invalid winner codes must leave the block idle.
    foreach (bad_codes[i]) begin
      activity = 0;
      go = 1'b1; start = bad_codes[i];
      @(negedge clk);
      go = 1'b0;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) activity++;
      end
      check($sformatf("bad_start_%0d", bad_codes[i]), 32'(activity), 32'd0);
    end

    // go with start=5 mid-frame is ignored.
    run_frame("s2_inject", 3'd2, 31, 103, 0, 500, -1);

    // Reset at pixel 300 aborts; next go yields a full frame.
    run_frame("s2_reset", 3'd2, 31, 103, 0, -10, 302);
    run_frame("s4_after_reset", 3'd4, 30, 240, 0, -10, -1);

    // Sparse ROM: single visible pixel at addr 37 when transparency is built in.
    run_frame("sparse", 3'd3, 576, 240, 1, -10, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
